// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding select encoding, controller states and the bubble-count range.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } hz_state_e;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;
    // Wide enough to hold LOAD_LAT_MAX - 1.
    localparam int BUB_CNT_W    = 3;

    function automatic logic load_lat_ok(input int lat);
        return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select and load-use hit detection for one ID source.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    output fwd_sel_e          sel,
    output logic              ex_load_hit
);

    logic rs_live_s;
    logic ex_hit_s;
    logic mem_hit_s;
    logic wb_hit_s;

    // Stage match terms and forwarding priority; x0 never matches.
    always_comb begin
        rs_live_s   = rs_used && (rs != {REG_AW{1'b0}});
        ex_hit_s    = rs_live_s && ex_we  && (ex_rd  == rs);
        mem_hit_s   = rs_live_s && mem_we && (mem_rd == rs);
        wb_hit_s    = rs_live_s && wb_we  && (wb_rd  == rs);
        ex_load_hit = ex_hit_s && ex_is_load;
        sel         = FWD_RF;
        // A load in MEM has no data yet, so it falls through to WB.
        if (mem_hit_s && !mem_is_load) begin
            sel = FWD_MEM;
        end else if (wb_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles, redirect
// flushes, data-memory freeze and saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we,
    input  logic              id_redirect,
    input  logic              ex_redirect,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    if (!load_lat_ok(LOAD_LAT)) begin : g_bad_load_lat
        $error("hazard_ctrl: LOAD_LAT out of range");
    end

    localparam logic [BUB_CNT_W-1:0] BUB_LOAD = BUB_CNT_W'(LOAD_LAT - 1);
    localparam logic [PERF_W-1:0]    PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0]    PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    hz_state_e            state_r;
    hz_state_e            state_nxt_s;
    logic [BUB_CNT_W-1:0] bub_cnt_r;
    logic [BUB_CNT_W-1:0] bub_cnt_nxt_s;
    fwd_sel_e             fwd_a_s;
    fwd_sel_e             fwd_b_s;
    logic                 lu_a_s;
    logic                 lu_b_s;
    logic                 lu_s;
    logic                 freeze_s;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (id_rs1),
        .rs_used     (id_rs1_used),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .sel         (fwd_a_s),
        .ex_load_hit (lu_a_s)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (id_rs2),
        .rs_used     (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_we       (ex_we),
        .ex_is_load  (ex_is_load),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_is_load (mem_is_load),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .sel         (fwd_b_s),
        .ex_load_hit (lu_b_s)
    );

    // Next-state and control outputs, in priority order freeze > ex_redirect > load-use > id_redirect.
    always_comb begin
        lu_s          = lu_a_s || lu_b_s;
        freeze_s      = dmem_req && !dmem_ready;
        state_nxt_s   = state_r;
        bub_cnt_nxt_s = bub_cnt_r;
        fwd_a         = 2'b00;
        fwd_b         = 2'b00;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        if (rst) begin
            state_nxt_s   = RUN;
            bub_cnt_nxt_s = {BUB_CNT_W{1'b0}};
        end else begin
            fwd_a = fwd_a_s;
            fwd_b = fwd_b_s;
            if (freeze_s) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                state_nxt_s   = RUN;
                bub_cnt_nxt_s = {BUB_CNT_W{1'b0}};
            end else if (state_r == LOAD_WAIT) begin
                // The dependent stays held in ID, so id_redirect is ignored here.
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                if (bub_cnt_r <= {{(BUB_CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s   = RUN;
                    bub_cnt_nxt_s = {BUB_CNT_W{1'b0}};
                end else begin
                    bub_cnt_nxt_s = bub_cnt_r - {{(BUB_CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (lu_s) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_nxt_s   = LOAD_WAIT;
                    bub_cnt_nxt_s = BUB_LOAD;
                end else begin
                    state_nxt_s = RUN;
                end
            end else if (id_redirect) begin
                if_id_flush = 1'b1;
            end else begin
                state_nxt_s = RUN;
            end
        end
    end

    // Controller state and remaining bubble count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RUN;
            bub_cnt_r <= {BUB_CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            bub_cnt_r <= bub_cnt_nxt_s;
        end
    end

    // Saturating performance counters for stall cycles and redirect flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= {PERF_W{1'b0}};
            flush_events <= {PERF_W{1'b0}};
        end else begin
            if (pc_stall && (stall_cycles != PERF_MAX)) begin
                stall_cycles <= stall_cycles + PERF_ONE;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (if_id_flush && (flush_events != PERF_MAX)) begin
                flush_events <= flush_events + PERF_ONE;
            end else begin
                flush_events <= flush_events;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LOAD_LAT=3 and 4-bit perf counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_we, ex_is_load, mem_we, mem_is_load, wb_we;
    logic       id_redirect, ex_redirect, dmem_req, dmem_ready;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [3:0] stall_cycles, flush_events;

    int n_cmp = 0;
    int n_err = 0;
    int stall_seen;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .id_redirect(id_redirect), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0;
        mem_rd = 5'd0; mem_we = 1'b0; mem_is_load = 1'b0;
        wb_rd = 5'd0; wb_we = 1'b0;
        id_redirect = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic load_use_x7();
        clr_in();
        id_rs1 = 5'd7; id_rs1_used = 1'b1;
        ex_rd = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    endtask

    // Controls: {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush}
    function automatic logic [5:0] ctl();
        return {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
    endfunction

    initial begin
        // Reset with hazard-provoking inputs: everything must read 0.
        rst = 1'b1;
        clr_in();
        id_rs1 = 5'd5; id_rs1_used = 1'b1; mem_rd = 5'd5; mem_we = 1'b1;
        id_redirect = 1'b1; dmem_req = 1'b1;
        #2;
        chk("rst_fwd_a", fwd_a, 2'd0);
        chk("rst_ctl", ctl(), 6'b000000);
        tick();
        chk("rst_stall_cnt", stall_cycles, 4'd0);
        chk("rst_flush_cnt", flush_events, 4'd0);
        clr_in();
        rst = 1'b0;
        #2;

        // Forwarding selects
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        mem_rd = 5'd5; mem_we = 1'b1; wb_rd = 5'd5; wb_we = 1'b1;
        #1; chk("fwd_mem", fwd_a, 2'd1);
        chk("fwd_b_unused", fwd_b, 2'd0);
        mem_is_load = 1'b1;
        #1; chk("fwd_mem_load_wb", fwd_a, 2'd2);
        id_rs2 = 5'd9; id_rs2_used = 1'b1; wb_rd = 5'd9;
        #1; chk("fwd_b_wb", fwd_b, 2'd2);
        chk("fwd_a_load_only", fwd_a, 2'd0);
        clr_in();
        mem_we = 1'b1; wb_we = 1'b1; id_rs1_used = 1'b1;
        #1; chk("fwd_x0", fwd_a, 2'd0);
        chk("fwd_no_ctl", ctl(), 6'b000000);
        clr_in();
        #1;

        // Load-use: three stall cycles
        load_use_x7();
        #1; chk("lu_c1", ctl(), 6'b110001);
        tick();
        ex_we = 1'b0; ex_is_load = 1'b0;
        #1; chk("lu_c2", ctl(), 6'b110001);
        tick();
        #1; chk("lu_c3", ctl(), 6'b110001);
        tick();
        #1; chk("lu_done", ctl(), 6'b000000);
        chk("lu_stall_cnt", stall_cycles, 4'd3);
        id_redirect = 1'b1;
        #1; chk("lu_run_idr", ctl(), 6'b000010);
        id_redirect = 1'b0;

        // Freeze for two cycles inside LOAD_WAIT
        load_use_x7();
        stall_seen = 0;
        #1; if (pc_stall) stall_seen++;
        tick();
        ex_we = 1'b0; ex_is_load = 1'b0;
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1; chk("frz_c1", ctl(), 6'b111100);
        if (pc_stall) stall_seen++;
        tick();
        #1; chk("frz_c2", ctl(), 6'b111100);
        if (pc_stall) stall_seen++;
        tick();
        dmem_ready = 1'b1;
        #1; chk("frz_resume1", ctl(), 6'b110001);
        if (pc_stall) stall_seen++;
        tick();
        dmem_req = 1'b0;
        #1; chk("frz_resume2", ctl(), 6'b110001);
        if (pc_stall) stall_seen++;
        tick();
        #1; if (pc_stall) stall_seen++;
        chk("frz_total", stall_seen, 5);
        chk("frz_stall_cnt", stall_cycles, 4'd8);

        // ex_redirect on second bubble aborts LOAD_WAIT
        load_use_x7();
        tick();
        ex_we = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b1;
        #1; chk("exr_lw", ctl(), 6'b000011);
        tick();
        ex_redirect = 1'b0; id_redirect = 1'b1;
        #1; chk("exr_flush_cnt", flush_events, 4'd1);
        chk("exr_back_run", ctl(), 6'b000010);
        chk("exr_stall_cnt", stall_cycles, 4'd9);
        tick();
        chk("idr_flush_cnt", flush_events, 4'd2);

        // Simultaneous redirects, then freeze outranks redirect
        ex_redirect = 1'b1;
        #1; chk("both_redirect", ctl(), 6'b000011);
        tick();
        chk("both_flush_cnt", flush_events, 4'd3);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1; chk("frz_over_exr", ctl(), 6'b111100);
        tick();
        chk("frz_exr_flush_cnt", flush_events, 4'd3);
        chk("frz_exr_stall_cnt", stall_cycles, 4'd10);

        // Saturation after 20 more stall cycles
        clr_in();
        dmem_req = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall_cnt", stall_cycles, 4'd15);

        // Async reset in the middle of LOAD_WAIT
        load_use_x7();
        tick();
        ex_we = 1'b0; ex_is_load = 1'b0;
        #1; chk("pre_rst_lw", ctl(), 6'b110001);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", ctl(), 6'b000000);
        chk("mid_rst_stall_cnt", stall_cycles, 4'd0);
        chk("mid_rst_flush_cnt", flush_events, 4'd0);
        rst = 1'b0;
        clr_in();
        id_redirect = 1'b1;
        #1; chk("post_rst_run", ctl(), 6'b000010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised successor to the pipeline's combinational hazard unit. It resolves data hazards through forwarding selects, load-use stalls with configurable bubble count, redirect flushes from ID and EX, and full-pipeline freeze on data-memory wait. A small FSM plus counters sit between the stage registers and the PC/IF/ID/EX enables. Saturating stall/flush performance counters are exported.

Parameters:
REG_AW, 5, register address width; address 0 never writable
LOAD_LAT, 1, bubbles needed between a load in EX and a dependent in ID (1..4)
PERF_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_rs1  in  REG_AW  ID source 1 address
id_rs2  in  REG_AW  ID source 2 address
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  EX destination
ex_we  in  1  EX writes register file
ex_is_load  in  1  EX instruction is a load
mem_rd  in  REG_AW  MEM destination
mem_we  in  1  MEM writes register file
mem_is_load  in  1  MEM instruction is a load
wb_rd  in  REG_AW  WB destination
wb_we  in  1  WB writes register file
id_redirect  in  1  jump resolved in ID
ex_redirect  in  1  branch/jalr taken, resolved in EX
dmem_req  in  1  MEM stage has an outstanding access
dmem_ready  in  1  data memory completes this cycle
fwd_a  out  2  operand A select: 0 regfile, 1 MEM ALU result, 2 WB data
fwd_b  out  2  operand B select, same encoding
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  bubble ID/EX
ex_mem_stall  out  1  hold EX/MEM
stall_cycles  out  PERF_W  saturating count of stall cycles
flush_events  out  PERF_W  saturating count of redirect events

Behaviour:
- Reset: state RUN, bubble counter 0, both perf counters 0. While rst is high, all outputs are 0.
- Forwarding is combinational. A source matches a stage when it is used, rd != 0, that stage's we is 1 and the addresses are equal.
- Forwarding priority: MEM match with mem_is_load=0 gives 1. Otherwise a WB match gives 2. Otherwise 0. A MEM load match never selects 1.
- Load-use detect (LU): an ID source matches EX with ex_is_load=1.
- Priority, highest first: MEM_WAIT freeze > ex_redirect > LU / LOAD_WAIT > id_redirect > none.
- Freeze, when dmem_req & !dmem_ready: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall are all 1. No flush is asserted. The FSM holds its state and the counter does not decrement.
- ex_redirect, when not frozen: if_id_flush=1 and id_ex_flush=1, no stalls. Any LOAD_WAIT is aborted: next state RUN, counter cleared.
- LU in RUN, when not frozen: pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle.
  - LOAD_LAT=1: stay in RUN.
  - LOAD_LAT>1: counter loads LOAD_LAT-1, next state LOAD_WAIT.
- LOAD_WAIT: the same stall/flush outputs apply every cycle. The counter decrements each unfrozen cycle; when it reaches 1, next state is RUN. An id_redirect in LOAD_WAIT is ignored (the instruction is held).
- id_redirect, in RUN with no LU: if_id_flush=1 only.
- States: RUN, LOAD_WAIT. Transitions occur only on unfrozen cycles, except the reset and ex_redirect aborts described above.
- stall_cycles increments on any cycle where pc_stall=1. flush_events increments on any cycle where if_id_flush=1. Both saturate at all-ones and do not wrap.
- Latency: every control output is combinational from inputs and state in the same cycle. State and counters update on the rising edge of clk.

Decomposition:
- hazard_pkg: fwd_sel_e enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2), hz_state_e enum (RUN, LOAD_WAIT), and the LOAD_LAT range check constant.
- Sub-module hazard_fwd_sel: per-operand match and priority logic, instantiated twice (operands A and B).

Test Plan:
- Forwarding: x5 written in MEM and WB, ID reads rs1=5 -> fwd_a=1. With mem_is_load=1 -> fwd_a=2. rs1=0 with all rd=0 -> fwd_a=0.
- Load-use: LOAD_LAT=3, load to x7 in EX, ID uses x7 -> pc_stall=1 for exactly 3 cycles, id_ex_flush=1 each of those cycles, stall_cycles=3, state returns to RUN.
- Freeze inside LOAD_WAIT: dmem_req=1, dmem_ready=0 for 2 cycles -> all four stalls high and no flush. The remaining bubble count resumes afterwards; total pc_stall=LOAD_LAT+2.
- ex_redirect in LOAD_WAIT, second bubble -> both flushes=1, stalls=0 that cycle, next state RUN, flush_events increments by 1.
- id_redirect with no hazard -> if_id_flush=1 only. Simultaneous id_redirect and ex_redirect -> both flushes=1.
- Saturation: PERF_W=4, force 20 stall cycles -> stall_cycles=15. Assert rst mid-LOAD_WAIT -> all outputs 0 immediately, counters 0, state RUN.
